datapath_mux_unit: RTL and testbench

- Datapath selection unit for the single-cycle processor. It holds two independent multiplexers:
  - A 2:1 data mux, 32 bits wide, which selects the ALU operand or write-back data.
  - A 3:1 register-index mux, 5 bits wide, which selects the destination register number (rt, rd or 31).
- Mux outputs are combinational so the single-cycle path has no latency added.
- Each mux output also has a registered copy, and an illegal-select error flag is provided. Both are for pipeline/debug observation.

---
 rtl/datapath_mux_unit.sv | 42 ++++
 tb/tb_datapath_mux_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/datapath_mux_unit.sv
// datapath_mux_unit: 2:1 data mux and 3:1 register-index mux with registered copies and illegal-select error flags (clk, rst, sel2/d2_*->y2, sel3/d3_*->y3, y2_q, y3_q, sel3_err, sel3_err_sticky)
module datapath_mux_unit #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel2,
  input  logic [DW-1:0] d2_0,
  input  logic [DW-1:0] d2_1,
  output logic [DW-1:0] y2,
  input  logic [1:0]    sel3,
  input  logic [RW-1:0] d3_0,
  input  logic [RW-1:0] d3_1,
  input  logic [RW-1:0] d3_2,
  output logic [RW-1:0] y3,
  output logic [DW-1:0] y2_q,
  output logic [RW-1:0] y3_q,
  output logic          sel3_err,
  output logic          sel3_err_sticky
);
  logic sticky_d;
  always_comb begin
    y2       = sel2 ? d2_1 : d2_0;
    y3       = sel3 == 2'b00 ? d3_0 :
               sel3 == 2'b01 ? d3_1 :
               sel3 == 2'b10 ? d3_2 : '0;
    sel3_err = sel3 == 2'b11;
    sticky_d = sel3_err_sticky | sel3_err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      y2_q            <= '0;
      y3_q            <= '0;
      sel3_err_sticky <= 1'b0;
    end else begin
      y2_q            <= y2;
      y3_q            <= y3;
      sel3_err_sticky <= sticky_d;
    end
  end
endmodule

// File: tb/tb_datapath_mux_unit.sv
// tb_datapath_mux_unit: table-driven self-checking bench for datapath_mux_unit
module tb_datapath_mux_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel2 = 1'b0;
  logic [31:0] d2_0 = 32'h1234_5678;
  logic [31:0] d2_1 = 32'h8765_4321;
  logic [31:0] y2, y2_q;
  logic [1:0]  sel3 = 2'b00;
  logic [4:0]  d3_0 = 5'd0, d3_1 = 5'd1, d3_2 = 5'd2;
  logic [4:0]  y3, y3_q;
  logic        sel3_err, sel3_err_sticky;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct packed {
    logic        s2;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  s3;
    logic [4:0]  c0;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [31:0] ey2;
    logic [4:0]  ey3;
    logic        eerr;
    logic        estk;
  } vec_t;
  vec_t v [8];
  datapath_mux_unit #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .sel2(sel2), .d2_0(d2_0), .d2_1(d2_1), .y2(y2),
    .sel3(sel3), .d3_0(d3_0), .d3_1(d3_1), .d3_2(d3_2), .y3(y3),
    .y2_q(y2_q), .y3_q(y3_q), .sel3_err(sel3_err), .sel3_err_sticky(sel3_err_sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    v[0] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 2'b00, 5'd0, 5'd1, 5'd2, 32'h1234_5678, 5'd0, 1'b0, 1'b0};
    v[1] = '{1'b1, 32'h1234_5678, 32'h8765_4321, 2'b01, 5'd0, 5'd1, 5'd2, 32'h8765_4321, 5'd1, 1'b0, 1'b0};
    v[2] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 2'b10, 5'd0, 5'd1, 5'd2, 32'h1234_5678, 5'd2, 1'b0, 1'b0};
    v[3] = '{1'b1, 32'h1234_5678, 32'h8765_4321, 2'b11, 5'd0, 5'd1, 5'd2, 32'h8765_4321, 5'd0, 1'b1, 1'b1};
    v[4] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 2'b00, 5'd0, 5'd1, 5'd2, 32'h1234_5678, 5'd0, 1'b0, 1'b1};
    v[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 5'h1F, 5'h1F, 5'h1F, 32'h0000_0000, 5'd0, 1'b1, 1'b1};
    v[6] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0001, 2'b10, 5'h0A, 5'h15, 5'h1F, 32'hDEAD_BEEF, 5'h1F, 1'b0, 1'b1};
    v[7] = '{1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 2'b01, 5'h0A, 5'h15, 5'h1F, 32'h0000_0001, 5'h15, 1'b0, 1'b1};
    @(posedge clk);
    #1 chk("y2 during reset", y2, 32'h1234_5678);
    @(negedge clk);
    sel2 = 1'b1;
    #1 chk("y2 tracks during reset", y2, 32'h8765_4321);
    @(posedge clk);
    #1;
    chk("reset y2_q", y2_q, 32'h0);
    chk("reset y3_q", {27'd0, y3_q}, 32'h0);
    chk("reset sticky", {31'd0, sel3_err_sticky}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sel2 = v[i].s2; d2_0 = v[i].a; d2_1 = v[i].b;
      sel3 = v[i].s3; d3_0 = v[i].c0; d3_1 = v[i].c1; d3_2 = v[i].c2;
      #1;
      chk($sformatf("v%0d y2", i), y2, v[i].ey2);
      chk($sformatf("v%0d y3", i), {27'd0, y3}, {27'd0, v[i].ey3});
      chk($sformatf("v%0d sel3_err", i), {31'd0, sel3_err}, {31'd0, v[i].eerr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d y2_q", i), y2_q, v[i].ey2);
      chk($sformatf("v%0d y3_q", i), {27'd0, y3_q}, {27'd0, v[i].ey3});
      chk($sformatf("v%0d sticky", i), {31'd0, sel3_err_sticky}, {31'd0, v[i].estk});
    end
    @(negedge clk);
    rst = 1'b1; sel3 = 2'b11; d3_0 = 5'h07; d3_1 = 5'h0B; d3_2 = 5'h0D; sel2 = 1'b0; d2_0 = 32'hA5A5_5A5A;
    #1;
    chk("rst+illegal y3", {27'd0, y3}, 32'h0);
    chk("rst+illegal sel3_err", {31'd0, sel3_err}, 32'h1);
    @(posedge clk);
    #1;
    chk("rst+illegal sticky", {31'd0, sel3_err_sticky}, 32'h0);
    chk("rst+illegal y3_q", {27'd0, y3_q}, 32'h0);
    chk("rst+illegal y2_q", y2_q, 32'h0);
    chk("rst+illegal y2 live", y2, 32'hA5A5_5A5A);
    @(negedge clk);
    rst = 1'b0; sel3 = 2'b00;
    @(posedge clk);
    #1;
    chk("post-rst sticky", {31'd0, sel3_err_sticky}, 32'h0);
    chk("post-rst y3_q", {27'd0, y3_q}, 32'h07);
    chk("post-rst y2_q", y2_q, 32'hA5A5_5A5A);
    @(negedge clk);
    sel2 = 1'b1; d2_0 = 32'h0;
    for (int i = 0; i < 32; i++) begin
      d2_1 = 32'h1 << i;
      #1 chk($sformatf("walk%0d y2", i), y2, 32'h1 << i);
    end
    @(posedge clk);
    #1 chk("walk31 y2_q", y2_q, 32'h8000_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
